// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Plain vectors keep the FSM register a simple logic bus for older flows.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Signed overflow of a - b from the operand sign bits and the result sign bit.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Operand and result handshake bundle for serial_sub; ovf exists only with SERIAL_SUB_OVF_EN.
interface serial_sub_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  borrow
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output borrow
  );

endinterface

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: d = x - y - bin, bout set when the bit borrows.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b, LSB first: result valid WIDTH cycles after accept, held stable until out_ready.
// Optional signed overflow flag with SERIAL_SUB_OVF_EN; only one operand in flight, in_ready only in IDLE.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  assign accept   = bus.in_valid & bus.in_ready;
  assign last_bit = (cnt_q == CNT_LAST);

  full_sub u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          sd_d    = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        sd_d = sd_q >> 1;
        sd_d[WIDTH-1] = cell_d;
        br_d = cell_bout;
        if (last_bit) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.diff      = sd_q;
  assign bus.borrow    = br_q;

`ifdef SERIAL_SUB_OVF_EN
  logic am_q, am_d;
  logic bm_q, bm_d;
  logic ovf_q, ovf_d;

  always_comb begin
    am_d  = am_q;
    bm_d  = bm_q;
    ovf_d = ovf_q;
    if (state_q == ST_IDLE && accept) begin
      am_d  = bus.a[WIDTH-1];
      bm_d  = bus.b[WIDTH-1];
      ovf_d = 1'b0;
    end else if (state_q == ST_RUN && last_bit) begin
      // The final cell output is the result sign bit, so ovf settles on the same edge as diff.
      ovf_d = sub_ovf(am_q, bm_q, cell_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_q  <= 1'b0;
      bm_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      am_q  <= am_d;
      bm_q  <= bm_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  a_ready_valid_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.in_ready && bus.out_valid));

  a_hold_result : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.diff) && $stable(bus.borrow)));

  a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_DONE));

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at WIDTH=8 and WIDTH=1 with hand-computed results.
module tb_serial_sub;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  serial_sub_if #(.WIDTH(8)) bus8 ();
  serial_sub_if #(.WIDTH(1)) bus1 ();

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for out_valid on bus8 after an accept edge; returns the edge count.
  task automatic wait_valid8(output int n);
    n = 0;
    while (!bus8.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb, input logic eo, input string tag);
    int n;
    @(negedge clk);
    chk({tag, ":in_ready"}, bus8.in_ready, 1);
    bus8.a = ta;
    bus8.b = tb_v;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    wait_valid8(n);
    chk({tag, ":latency"}, n, 8);
    chk({tag, ":diff"}, bus8.diff, ed);
    chk({tag, ":borrow"}, bus8.borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, ":ovf"}, bus8.ovf, eo);
`else
    if (eo) n = 0;
`endif
    @(posedge clk); #1;
    chk({tag, ":released"}, bus8.out_valid, 0);
  endtask

  task automatic do_op1(input logic ta, input logic tb_v, input logic ed, input logic eb,
                        input logic eo, input string tag);
    int n;
    @(negedge clk);
    bus1.a = ta;
    bus1.b = tb_v;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    n = 0;
    while (!bus1.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":latency"}, n, 1);
    chk({tag, ":diff"}, bus1.diff, ed);
    chk({tag, ":borrow"}, bus1.borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, ":ovf"}, bus1.ovf, eo);
`else
    if (eo) n = 0;
`endif
    @(posedge clk); #1;
    chk({tag, ":released"}, bus1.out_valid, 0);
  endtask

  initial begin
    int n;
    int seen;
    vec_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;

    #1;
    chk("rst:out_valid", bus8.out_valid, 0);
    chk("rst:diff", bus8.diff, 0);
    chk("rst:borrow", bus8.borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst:ovf", bus8.ovf, 0);
`endif
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst:in_ready", bus8.in_ready, 1);

    do_op8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, "5a_23");
    do_op8(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "10_20");
    do_op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "80_01");
    do_op8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "wrap");

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    bus8.out_ready = 1'b0;
    @(negedge clk);
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    wait_valid8(n);
    chk("hold:latency", n, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus8.a = 8'hAA; bus8.b = 8'h11; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      chk("hold:out_valid", bus8.out_valid, 1);
      chk("hold:in_ready", bus8.in_ready, 0);
      chk("hold:diff", bus8.diff, 8'hF0);
      chk("hold:borrow", bus8.borrow, 1);
    end
    @(negedge clk);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold:to_idle_valid", bus8.out_valid, 0);
    chk("hold:to_idle_ready", bus8.in_ready, 1);
    do_op8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "7f_ff");

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort:out_valid", bus8.out_valid, 0);
    chk("abort:in_ready", bus8.in_ready, 1);
    chk("abort:diff", bus8.diff, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus8.out_valid) seen++;
    end
    chk("abort:no_result", seen, 0);
    do_op8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "ff_ff");

    do_op1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "w1_0_1");
    do_op1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "w1_1_0");
    do_op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "w1_1_1");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
